// File: rtl/pixel_burst_writer.sv
// pixel_burst_writer: gathers pixel pairs into a 32-byte VRAM block
// (8 words x 32 bits, 16 pixels with per-pixel write mask) and writes each
// completed or flushed block out as an 8-beat burst.
//
// Two buffers are used. The fill buffer collects pairs that share one block
// key. The flush buffer holds the block currently being written to memory.
// A transfer copies fill into flush and clears the fill words. This lets the
// upstream keep writing into the next block while a burst is still running.
module pixel_burst_writer (
  input  logic        clk,
  input  logic        i_nrst,
  input  logic [31:0] i_write32,
  input  logic [1:0]  i_pixelValid,
  input  logic        i_writePixel,
  input  logic [8:0]  i_pairX,
  input  logic [8:0]  i_scrY,
  input  logic        i_flush,
  output logic        o_okNext,
  output logic        o_memReq,
  output logic [14:0] o_memAdr,
  output logic [15:0] o_memMask,
  input  logic        i_memAck,
  output logic        o_memDataValid,
  output logic [31:0] o_memData,
  input  logic        i_memReady,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Flush FSM state and burst beat counter
  state_t      state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic        pending_flush_q, pending_flush_d;

  // Fill buffer
  logic        fill_valid_q, fill_valid_d;
  logic [14:0] fill_key_q, fill_key_d;
  logic [15:0] fill_mask_q, fill_mask_d;
  logic [31:0] fill_words_q [8];
  logic [31:0] fill_words_d [8];

  // Flush buffer
  logic [14:0] flush_key_q, flush_key_d;
  logic [15:0] flush_mask_q, flush_mask_d;
  logic [31:0] flush_words_q [8];
  logic [31:0] flush_words_d [8];

  // Decoded view of the incoming pair
  logic [14:0] pair_key;
  logic [2:0]  pair_idx;
  logic [15:0] pair_bits;
  logic        is_idle;
  logic        accept;
  logic        key_hit;
  logic        flush_req;
  logic        fill_full;
  logic        transfer_go;

  assign pair_key  = {i_scrY, i_pairX[8:3]};
  assign pair_idx  = i_pairX[2:0];
  assign pair_bits = {14'd0, i_pixelValid} << {pair_idx, 1'b0};

  assign is_idle   = (state_q == ST_IDLE);
  // o_okNext depends on registered state only, so this accept has no
  // combinational loop back to the upstream handshake.
  assign o_okNext  = !(fill_valid_q && !is_idle);
  assign accept    = i_writePixel && (i_pixelValid != 2'b00) && o_okNext;
  assign key_hit   = fill_valid_q && (fill_key_q == pair_key);
  assign flush_req = i_flush || pending_flush_q;
  assign fill_full = (fill_mask_q == 16'hFFFF);

  // A transfer can only happen while the flush buffer is free (IDLE).
  // Cause 1: an accepted pair belongs to another block.
  // Cause 2: there is no accept and a flush is requested, or the block is
  //          completely covered.
  // If a same-key pair arrives in the same cycle, it is merged first. The
  // full/flush transfer then follows on the next cycle.
  assign transfer_go = is_idle && fill_valid_q &&
                       (accept ? !key_hit : (flush_req || fill_full));

  assign o_memReq       = (state_q == ST_REQ);
  assign o_memDataValid = (state_q == ST_DATA);
  assign o_memAdr       = is_idle ? 15'd0 : flush_key_q;
  assign o_memMask      = is_idle ? 16'd0 : flush_mask_q;
  assign o_memData      = (state_q == ST_DATA) ? flush_words_q[beat_q] : 32'd0;
  assign o_busy         = fill_valid_q || !is_idle || pending_flush_q;

  // Flush FSM next-state: IDLE -> REQ on transfer, REQ -> DATA on ack,
  // DATA -> IDLE after beat 7 is accepted
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (transfer_go) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_memAck) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (i_memReady) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = 3'd0;
      end
    endcase
  end

  // Pending flush: remember a flush that arrives while a burst is running
  // (or while a same-key pair is merging) so it is honoured once IDLE
  always_comb begin
    pending_flush_d = pending_flush_q;
    if (!is_idle) begin
      pending_flush_d = pending_flush_q || i_flush;
    end else if (transfer_go) begin
      // A key-change transfer starts a new fill. Keep any request for it.
      pending_flush_d = accept ? flush_req : 1'b0;
    end else if (accept) begin
      pending_flush_d = flush_req;
    end else begin
      pending_flush_d = 1'b0;
    end
  end

  // Fill/flush buffer update: transfer first, then apply the accepted pair
  always_comb begin
    fill_valid_d = fill_valid_q;
    fill_key_d   = fill_key_q;
    fill_mask_d  = fill_mask_q;
    flush_key_d  = flush_key_q;
    flush_mask_d = flush_mask_q;
    for (int i = 0; i < 8; i++) begin
      fill_words_d[i]  = fill_words_q[i];
      flush_words_d[i] = flush_words_q[i];
    end

    if (transfer_go) begin
      flush_key_d  = fill_key_q;
      flush_mask_d = fill_mask_q;
      for (int i = 0; i < 8; i++) begin
        flush_words_d[i] = fill_words_q[i];
        fill_words_d[i]  = 32'd0;
      end
      fill_mask_d  = 16'd0;
      fill_valid_d = 1'b0;
    end

    if (accept) begin
      if (transfer_go || !fill_valid_q) begin
        // Fresh block: words are already zero (reset or transfer clear)
        fill_key_d  = pair_key;
        fill_mask_d = pair_bits;
      end else begin
        fill_mask_d = fill_mask_q | pair_bits;
      end
      fill_valid_d = 1'b1;
      if (i_pixelValid[0]) begin
        fill_words_d[pair_idx][15:0] = i_write32[15:0];
      end
      if (i_pixelValid[1]) begin
        fill_words_d[pair_idx][31:16] = i_write32[31:16];
      end
    end
  end

  // State register; reset abandons any burst in progress
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q         <= ST_IDLE;
      beat_q          <= 3'd0;
      pending_flush_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      pending_flush_q <= pending_flush_d;
    end
  end

  // Buffer registers
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      fill_valid_q <= 1'b0;
      fill_key_q   <= 15'd0;
      fill_mask_q  <= 16'd0;
      flush_key_q  <= 15'd0;
      flush_mask_q <= 16'd0;
      for (int i = 0; i < 8; i++) begin
        fill_words_q[i]  <= 32'd0;
        flush_words_q[i] <= 32'd0;
      end
    end else begin
      fill_valid_q <= fill_valid_d;
      fill_key_q   <= fill_key_d;
      fill_mask_q  <= fill_mask_d;
      flush_key_q  <= flush_key_d;
      flush_mask_q <= flush_mask_d;
      for (int i = 0; i < 8; i++) begin
        fill_words_q[i]  <= fill_words_d[i];
        flush_words_q[i] <= flush_words_d[i];
      end
    end
  end

endmodule

// File: doc/pixel_burst_writer.md
PIXEL_BURST_WRITER -- requirements
Module: pixel_burst_writer

Interface
REQ-001 SHALL have no parameters; the burst is fixed at 8 words of 32 bits (16 pixels, one 32-byte VRAM block).
REQ-002 SHALL have ports clk in 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_nrst in 1, asynchronous active-low reset.
REQ-004 SHALL have port i_write32 in 32, a pixel pair: [15:0] is the left pixel, [31:16] is the right pixel.
REQ-005 SHALL have port i_pixelValid in 2, per-pixel valid: bit0 is left, bit1 is right.
REQ-006 SHALL have port i_writePixel in 1, qualifies the pixel pair.
REQ-007 SHALL have ports i_pairX in 9 (screen X divided by 2) and i_scrY in 9 (screen Y).
REQ-008 SHALL have port i_flush in 1, end-of-primitive request to write out the pending block.
REQ-009 SHALL have port o_okNext out 1, upstream may present the next pair.
REQ-010 SHALL have ports o_memReq out 1, o_memAdr out 15 (block address {Y, pairX[8:3]}), o_memMask out 16 (per-pixel write enable), i_memAck in 1.
REQ-011 SHALL have ports o_memDataValid out 1, o_memData out 32, i_memReady in 1.
REQ-012 SHALL have port o_busy out 1, asserted while any pixel is pending or being written.

Function
REQ-013 SHALL accept a pair when i_writePixel=1, i_pixelValid!=0 and o_okNext=1; a pair with i_pixelValid=0 SHALL be ignored with no state change.
REQ-014 SHALL hold a fill buffer: fillValid, 15-bit key, 8x32-bit words, 16-bit mask.
REQ-015 Key SHALL be {i_scrY, i_pairX[8:3]}; word index SHALL be i_pairX[2:0]; mask bits SHALL be [2*idx] for left and [2*idx+1] for right.
REQ-016 On accept with fill empty: SHALL load the key, clear the mask, write the valid halves, set their mask bits, and set fillValid.
REQ-017 On accept with the same key: SHALL overwrite only the valid halves (last write wins) and OR the mask bits.
REQ-018 On accept with a different key (flush FSM in IDLE): SHALL transfer the fill buffer to the flush buffer in that cycle, and the new pair SHALL start a fresh fill buffer.
REQ-019 o_okNext SHALL equal !(fillValid && flushState!=IDLE), registered-state only, with no combinational path from inputs.
REQ-020 When i_flush=1, fillValid=1 and FSM is IDLE with no accept that cycle: SHALL transfer fill to flush and clear fillValid.
REQ-021 If i_flush=1 while the FSM is busy, SHALL latch a pending flush and honour it on the first IDLE cycle.
REQ-022 If the fill mask is 0xFFFF and the FSM is IDLE: SHALL auto-transfer the next cycle without waiting for a key change.
REQ-023 Flush FSM states and transitions:
- IDLE -> REQ on transfer.
- REQ: o_memReq=1, o_memAdr/o_memMask stable; REQ -> DATA when i_memAck=1.
- DATA: o_memDataValid=1, o_memData=word[beat]; the 3-bit beat counter increments on i_memReady.
- DATA -> IDLE when beat 7 is accepted.
REQ-024 All 8 beats SHALL be sent regardless of mask; masked-off halves SHALL carry the buffer content (zero after a transfer clear).
REQ-025 Transfer SHALL clear the fill words to zero.
REQ-026 o_busy SHALL equal fillValid | (state!=IDLE) | pendingFlush.
REQ-027 Latency: the first o_memReq SHALL assert 1 cycle after the transfer edge; minimum total is 10 cycles from transfer to IDLE.

Reset
REQ-028 While i_nrst=0, all outputs SHALL be 0 except o_okNext=1, with state IDLE, fillValid=0, pendingFlush=0, beat=0, words and mask cleared.
REQ-029 Reset asserted mid-burst SHALL abandon the burst immediately; no partial resume after release.

Verification
REQ-030 Scenario: 8 pairs at Y=5, pairX=16..23 (all valid) -> auto-transfer; o_memAdr=0x0142, mask 0xFFFF, beats in X order.
REQ-031 Scenario: pair pairX=3 with valid=01, then pairX=3 with valid=10 and a different right pixel, then i_flush -> mask 0x00C0, word3 holds both halves, 8 beats.
REQ-032 Scenario: pairX=0 at Y=0, then pairX=8 at Y=0 with i_memAck held low -> first block in REQ; o_okNext=0 until ack and 8 beats complete.
REQ-033 Scenario: i_memReady toggled 1/0 during DATA -> beats advance only on ready; o_memData stable while not ready.
REQ-034 Scenario: i_flush pulsed during DATA with fill pending -> second burst starts on the cycle after IDLE.
REQ-035 Scenario: i_nrst low at beat 4 -> outputs immediately reset values; after release o_busy=0 and no request is issued.
